// File: rtl/instr_mem_fetch.sv
// ---------------------------------------------------------------------------
// instr_mem_fetch
//   Parametrised instruction store. The program is streamed in through the
//   loader port while in LOAD. Once the final word arrives the block switches
//   to RUN and serves fetch requests. Each fetch is a registered read with a
//   1-cycle latency, so the fetch stage can stall on either side.
//   Reset does not clear the memory contents.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   ld_start   pulse: (re)enter LOAD, write pointer and ld_ovf cleared
//   ld_valid   loader word present (ignored in RUN)
//   ld_data    word written at mem[wptr]
//   ld_last    with ld_valid: final word, go to RUN
//   ld_ovf     sticky: a load word was dropped because wptr >= DEPTH
//   running    1 in RUN; this is the FSM state as seen from outside
//   req_valid  fetch request
//   req_addr   fetch word address
//   req_ready  request accepted when req_valid & req_ready
//   rsp_valid  response present
//   rsp_instr  fetched instruction (NOP when out of range)
//   rsp_addr   address that produced rsp_instr
//   rsp_err    request address was >= DEPTH
//   rsp_ready  consumer takes response
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1. While rsp_valid is 1 and rsp_ready is 0, all rsp_* hold steady and no new
// request is accepted. ld_start discards a pending response.
// ---------------------------------------------------------------------------
module instr_mem_fetch #(
  parameter int                DATA_W = 16,
  parameter int                ADDR_W = 16,
  parameter int                DEPTH  = 128,
  parameter logic [DATA_W-1:0] NOP    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ovf,
  output logic              running,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              rsp_ready
);

  // The write pointer must be able to hold DEPTH itself (saturated value).
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  DEPTH_PTR  = PTR_W'(DEPTH);
  // DEPTH may equal 2**ADDR_W, so the range compare needs one extra bit.
  localparam logic [ADDR_W:0]   DEPTH_ADDR = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [PTR_W-1:0]  wptr_q;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic ld_accept;
  logic ld_in_range;
  logic mem_we;
  logic req_in_range;
  logic req_fire;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ld_start) begin
      state_d = LOAD;
    end else if ((state_q == LOAD) && ld_valid && ld_last) begin
      state_d = RUN;
    end
  end

  assign running = (state_q == RUN);

  // ---------------- loader ----------------
  // ld_start wins over ld_valid in the same cycle.
  assign ld_accept   = (state_q == LOAD) & ld_valid & ~ld_start;
  assign ld_in_range = (wptr_q < DEPTH_PTR);
  assign mem_we      = rst_n & ld_accept & ld_in_range;

  // Memory has no reset: contents survive reset and ld_start.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q[IDX_W-1:0]] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      ld_ovf <= 1'b0;
    end else if (ld_start) begin
      wptr_q <= '0;
      ld_ovf <= 1'b0;
    end else if (ld_accept) begin
      if (!ld_in_range) ld_ovf <= 1'b1;
      // Saturate at DEPTH so a long stream cannot wrap back into the store.
      if (wptr_q != DEPTH_PTR) wptr_q <= wptr_q + 1'b1;
    end
  end

  // ---------------- fetch ----------------
  assign req_ready    = running & (~rsp_valid | rsp_ready);
  assign req_fire     = req_valid & req_ready;
  assign req_in_range = ({1'b0, req_addr} < DEPTH_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_instr <= NOP;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
    end else if (ld_start) begin
      rsp_valid <= 1'b0;
    end else if (req_fire) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= req_addr;
      rsp_err   <= ~req_in_range;
      rsp_instr <= req_in_range ? mem[req_addr[IDX_W-1:0]] : NOP;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
module tb_instr_mem_fetch;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 128;
  localparam int RW     = 1 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ovf;
  logic              running;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_instr;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;
  logic              rsp_ready;

  instr_mem_fetch #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .NOP   (16'h0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ovf   (ld_ovf),
    .running  (running),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_instr(rsp_instr),
    .rsp_addr (rsp_addr),
    .rsp_err  (rsp_err),
    .rsp_ready(rsp_ready)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] model_mem [0:DEPTH-1];
  bit                known     [0:DEPTH-1];
  int                mwptr;
  bit                movf;
  bit                mrun;
  logic [RW-1:0]     exp_q[$];   // {err, addr, instr} of responses owed

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] expect_rsp(input logic [ADDR_W-1:0] a);
    if (int'(a) < DEPTH) return {1'b0, a, model_mem[int'(a)]};
    return {1'b1, a, 16'h0000};
  endfunction

  // One clock: check outputs mid-cycle, advance the model with this cycle's
  // inputs, then step to just after the rising edge.
  task automatic cycle();
    bit exp_ready;
    @(negedge clk);
    exp_ready = mrun && (exp_q.size() == 0 || rsp_ready);
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
    check("running",   64'(running),   64'(mrun));
    check("ld_ovf",    64'(ld_ovf),    64'(movf));
    if (exp_q.size() != 0)
      check("rsp_fields", 64'({rsp_err, rsp_addr, rsp_instr}), 64'(exp_q[0]));
    if (ld_start) begin
      exp_q.delete();
      mrun  = 1'b0;
      mwptr = 0;
      movf  = 1'b0;
    end else begin
      if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
      if (req_valid && exp_ready) exp_q.push_back(expect_rsp(req_addr));
      if (!mrun && ld_valid) begin
        if (mwptr < DEPTH) begin
          model_mem[mwptr] = ld_data;
          known[mwptr]     = 1'b1;
          mwptr++;
        end else begin
          movf = 1'b1;
        end
        if (ld_last) mrun = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    mrun = 1'b0; mwptr = 0; movf = 1'b0;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_instr", 64'(rsp_instr), 64'(16'h0000));
    check("rst_rsp_addr",  64'(rsp_addr),  64'(0));
    check("rst_rsp_err",   64'(rsp_err),   64'(0));
    check("rst_running",   64'(running),   64'(0));
    check("rst_ld_ovf",    64'(ld_ovf),    64'(0));
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    cycle();
    ld_start = 1'b0;
  endtask

  task automatic load_word(input logic [DATA_W-1:0] d, input bit last);
    if ($urandom_range(0, 3) == 0) cycle();   // occasional loader gap
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    cycle();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a);
    req_valid = 1'b1; req_addr = a;
    cycle();
  endtask

  task automatic drain();
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic random_fetch(input int n, input int max_known);
    for (int i = 0; i < n; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) == 0) req_addr = ADDR_W'($urandom_range(DEPTH, 65535));
      else                           req_addr = ADDR_W'($urandom_range(0, max_known));
      cycle();
    end
    drain();
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] prog [0:7];

  initial begin
    prog = '{16'h0001, 16'h0100, 16'h1590, 16'h1902,
             16'h3109, 16'h4400, 16'h8020, 16'h1231};
    ld_data = '0; req_addr = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    // Reset, then load the 8-word program.
    do_reset();
    for (int i = 0; i < 8; i++) load_word(prog[i], i == 7);
    check("running_after_load", 64'(running), 64'(1));

    // Back-to-back fetch of 0..7.
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) fetch(ADDR_W'(i));
    drain();

    // Stall: addr 3 held with rsp_ready=0 for 4 cycles.
    rsp_ready = 1'b0;
    fetch(16'd3);
    req_addr = 16'd4;
    repeat (4) cycle();
    check("stall_instr", 64'(rsp_instr), 64'(16'h1902));
    check("stall_ready", 64'(req_ready), 64'(0));
    rsp_ready = 1'b1;
    cycle();                       // consumes addr 3, accepts addr 4 same edge
    check("after_stall_addr",  64'(rsp_addr),  64'(4));
    check("after_stall_instr", 64'(rsp_instr), 64'(16'h3109));
    drain();

    // Out-of-range fetch.
    fetch(16'd200);
    check("oor_instr", 64'(rsp_instr), 64'(16'h0000));
    check("oor_err",   64'(rsp_err),   64'(1));
    check("oor_addr",  64'(rsp_addr),  64'(200));
    drain();

    // Randomized fetch traffic over the loaded program.
    random_fetch(200, 7);

    // Overflowing load of 130 words, with requests held up during LOAD.
    pulse_start();
    req_valid = 1'b1; req_addr = 16'd1;
    for (int i = 0; i < 130; i++) load_word(DATA_W'($urandom), i == 129);
    req_valid = 1'b0;
    check("ovf_sticky", 64'(ld_ovf), 64'(1));
    rsp_ready = 1'b1;
    fetch(16'd127);
    fetch(16'd128);
    drain();
    random_fetch(150, DEPTH - 1);

    // ld_start with a response pending discards it.
    rsp_ready = 1'b0;
    fetch(16'd5);
    req_valid = 1'b0;
    ld_start = 1'b1;
    cycle();
    ld_start = 1'b0;
    check("discard_rsp_valid", 64'(rsp_valid), 64'(0));
    check("discard_running",   64'(running),   64'(0));
    check("discard_ovf_clr",   64'(ld_ovf),    64'(0));

    // Reset mid-load after 3 words, then reload 2 words.
    for (int i = 0; i < 3; i++) load_word(DATA_W'($urandom), 1'b0);
    do_reset();
    load_word(16'hbeef, 1'b0);
    load_word(16'hcafe, 1'b1);
    rsp_ready = 1'b1;
    fetch(16'd0);
    check("reload_word0", 64'(rsp_instr), 64'(16'hbeef));
    fetch(16'd1);
    fetch(16'd2);                  // still the word from the interrupted load
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
